// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: word width, NOP encoding and reset PC.
// Macros are defined only if the including build has not already supplied them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0000
`endif
`ifndef IFETCH_RESET_PC
`define IFETCH_RESET_PC 32'h0000_0000
`endif

package ifetch_unit_pkg;

    localparam int                WORD_W           = `WORD_WIDTH;
    localparam logic [WORD_W-1:0] INST_NOP_WORD    = `INST_NOP;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = `IFETCH_RESET_PC;
    localparam int                PC_STEP          = 4;

    // A fetch target is legal only when word aligned.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding fetched entries ({pc, inst} or {pc, inst, adel}); flush empties it in one edge.
// Head entry is read straight from the slot registers so a pushed word is visible the cycle after the push.
module ifetch_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [DEPTH-1:0][DW-1:0] slots;
    logic [AW-1:0]            wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]            rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]            count_reg, count_next;
    logic                     do_push, do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_reg != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [DW-1:0] slot_reg;

        always_ff @(posedge clk) begin
            if (do_push && wr_ptr_reg == AW'(gi)) begin
                slot_reg <= push_data;
            end
        end

        assign slots[gi] = slot_reg;
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head_data = slots[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues word reads to a 1-cycle imem, buffers responses, hands {pc, inst} to decode.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirects halt fetch and deliver a single address-error marker.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int           W        = WORD_W,
    parameter logic [W-1:0] RESET_PC = W'(DEFAULT_RESET_PC),
    parameter int           DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_inst,
    output logic         out_adel
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam int DW = 2 * W + 1;
`else
    localparam int DW = 2 * W;
`endif

    logic [W-1:0]  pc_reg, pc_next;
    logic [W-1:0]  req_pc_reg, req_pc_next;
    logic          inflight_reg, inflight_next;
    logic [W-1:0]  redirect_target;
    logic          halt, pop, issue, push, credit_ok, fifo_empty;
    logic [CW-1:0] occ;
    logic [CW:0]   credit_used;
    logic [DW-1:0] push_data, head_data;

    assign imem_addr = pc_reg;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready & ~redirect_valid;

    // Every word in flight must already own a FIFO slot, so it can never be dropped.
    assign credit_used = {1'b0, occ} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);
    assign credit_ok   = credit_used < (CW + 1)'(DEPTH);
    assign issue       = ~halt & credit_ok & ~redirect_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic halt_reg, halt_next;
    logic marker_reg, marker_next;
    logic bad_target;

    assign bad_target      = misaligned(redirect_pc[1:0]);
    assign redirect_target = redirect_pc;
    assign halt            = halt_reg;
    assign push            = (inflight_reg | marker_reg) & ~redirect_valid;
    // While halted pc_reg still holds the faulting target, so it doubles as the marker PC.
    assign push_data       = marker_reg ? {pc_reg, INST_NOP_WORD, 1'b1}
                                        : {req_pc_reg, imem_data, 1'b0};

    always_comb begin
        halt_next   = halt_reg;
        marker_next = 1'b0;
        if (redirect_valid) begin
            halt_next   = bad_target;
            marker_next = bad_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            halt_reg   <= 1'b0;
            marker_reg <= 1'b0;
        end else begin
            halt_reg   <= halt_next;
            marker_reg <= marker_next;
        end
    end

    assign out_adel = out_valid & head_data[0];
    assign out_inst = out_valid ? head_data[W:1] : '0;
    assign out_pc   = out_valid ? head_data[2*W:W+1] : '0;
`else
    assign redirect_target = redirect_pc & ~W'(3);
    assign halt            = 1'b0;
    assign push            = inflight_reg & ~redirect_valid;
    assign push_data       = {req_pc_reg, imem_data};

    assign out_adel = 1'b0;
    assign out_inst = out_valid ? head_data[W-1:0] : '0;
    assign out_pc   = out_valid ? head_data[2*W-1:W] : '0;
`endif

    always_comb begin
        pc_next       = pc_reg;
        req_pc_next   = req_pc_reg;
        inflight_next = 1'b0;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (issue) begin
            inflight_next = 1'b1;
            req_pc_next   = pc_reg;
            pc_next       = pc_reg + W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            inflight_reg <= inflight_next;
        end
    end

    ifetch_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (occ),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed scoreboard bench for ifetch_unit driving a 1-cycle imem image with mem[i] = 32'h1000_0000 + i.
module tb_ifetch_unit;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] imem_addr, imem_data, redirect_pc, out_pc, out_inst;
    logic         redirect_valid, out_valid, out_ready, out_adel;
    logic [31:0]  mem [256];
    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_mis = 0;

    ifetch_unit #(.W(W), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_adel       (out_adel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr[9:2]];

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, pc[9:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(4 * i);
            e.inst = inst_at(e.pc);
            e.adel = 1'b0;
            sb.push_back(e);
        end
    endtask

    // Scores the handshake that the coming edge will complete, then advances one cycle.
    task automatic step_cycle();
        exp_t e;
        if (rst && out_valid && out_ready && !redirect_valid) begin
            $display("pop pc=%h inst=%h adel=%b", out_pc, out_inst, out_adel);
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_mis++;
                $error("FAIL sb_unexpected: observed pc %h expected no entry", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_inst", out_inst, e.inst);
                chk("pop_adel", 32'(out_adel), 32'(e.adel));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        sb.delete();
        step_cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        exp_t m;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);

        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_adel", 32'(out_adel), 0);
        chk("rst_addr", imem_addr, 0);

        // Reset release, full-rate stream.
        push_stream(32'h0, 10);
        rst = 1'b1;
        step_cycle(); chk("s1_valid_c1", 32'(out_valid), 0);
        step_cycle(); chk("s1_valid_c2", 32'(out_valid), 1);
        chk("s1_first_pc", out_pc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("s1_thru", 32'(out_valid), 1);
            step_cycle();
        end

        // Backpressure: head holds, pc stops DEPTH words ahead.
        out_ready = 1'b0;
        push_stream(32'd40, 12);
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            chk("s2_hold_valid", 32'(out_valid), 1);
            chk("s2_hold_pc", out_pc, 32'd40);
            chk("s2_pc_stall", imem_addr, 32'd40 + 32'(4 * DEPTH));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("s2_no_gap", 32'(out_valid), 1);
            step_cycle();
        end

        // Redirect with a full FIFO.
        out_ready = 1'b0;
        repeat (3) step_cycle();
        chk("s3_full_head", out_pc, 32'd88);
        do_redirect(32'h40);
        push_stream(32'h40, 6);
        chk("s3_valid_r1", 32'(out_valid), 0);
        step_cycle(); chk("s3_valid_r2", 32'(out_valid), 0);
        step_cycle(); chk("s3_valid_r3", 32'(out_valid), 1);
        chk("s3_pc", out_pc, 32'h40);
        chk("s3_inst", out_inst, 32'h1000_0010);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step_cycle();

        // Redirect coincident with a pop and an in-flight read.
        chk("s4_pre_valid", 32'(out_valid), 1);
        do_redirect(32'h100);
        push_stream(32'h100, 8);
        chk("s4_valid_r1", 32'(out_valid), 0);
        step_cycle(); chk("s4_valid_r2", 32'(out_valid), 0);
        step_cycle(); chk("s4_pc", out_pc, 32'h100);
        for (int i = 0; i < 8; i++) step_cycle();

        // Address wrap from the top of the space.
        do_redirect(32'hFFFF_FFF8);
        push_stream(32'hFFFF_FFF8, 6);
        step_cycle(); step_cycle();
        chk("wrap_first", out_pc, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step_cycle();

`ifndef IFETCH_ALIGN_CHECK_EN
        // Misaligned target is word aligned silently.
        do_redirect(32'h43);
        push_stream(32'h40, 4);
        step_cycle(); step_cycle();
        chk("align_force_pc", out_pc, 32'h40);
        for (int i = 0; i < 4; i++) step_cycle();
`else
        do_redirect(32'h42);
        m.pc = 32'h42; m.inst = 32'h0; m.adel = 1'b1;
        sb.push_back(m);
        chk("s6_valid_r1", 32'(out_valid), 0);
        step_cycle();
        chk("s6_marker_valid", 32'(out_valid), 1);
        chk("s6_marker_adel", 32'(out_adel), 1);
        step_cycle();
        for (int i = 0; i < 5; i++) begin
            chk("s6_halted", 32'(out_valid), 0);
            step_cycle();
        end
        do_redirect(32'h80);
        push_stream(32'h80, 4);
        step_cycle(); step_cycle();
        chk("s6_resume_pc", out_pc, 32'h80);
        for (int i = 0; i < 4; i++) step_cycle();
`endif

        // Mid-stream reset, then restart from RESET_PC.
        rst = 1'b0;
        sb.delete();
        step_cycle();
        chk("s5_valid", 32'(out_valid), 0);
        chk("s5_pc", out_pc, 0);
        chk("s5_inst", out_inst, 0);
        chk("s5_adel", 32'(out_adel), 0);
        chk("s5_addr", imem_addr, 0);
        push_stream(32'h0, 6);
        rst = 1'b1;
        step_cycle(); chk("s5_valid_c1", 32'(out_valid), 0);
        step_cycle(); chk("s5_valid_c2", 32'(out_valid), 1);
        for (int i = 0; i < 6; i++) step_cycle();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
